// File: rtl/mac_qmgr_if.sv
// mac_qmgr_if: Wishbone register-slave bus between the app_clk host and mac_qmgr
interface mac_qmgr_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [5:0]  wbs_adr_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_sel_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o
    );
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_sel_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/mac_qmgr.sv
// mac_qmgr: NQ saturating descriptor-queue counters with base/threshold regs, error capture and irq; QMGR_THRESH_EN enables thresholds
module mac_qmgr #(
    parameter int NQ       = 2,
    parameter int QCNT_WD  = 4,
    parameter int QBASE_WD = 10
) (
    input  logic                     app_clk,
    input  logic                     reset_n,
    mac_qmgr_if.slave                wb,
    input  logic [NQ-1:0]            qcnt_inc,
    input  logic [NQ-1:0]            qcnt_dec,
    output logic [NQ*QBASE_WD-1:0]   cfg_qbase_addr,
    output logic [NQ*QCNT_WD-1:0]    qcnt,
    output logic [NQ-1:0]            q_empty,
    output logic [NQ-1:0]            q_full,
    output logic                     irq
);
    localparam logic [QCNT_WD-1:0] CMAX = '1;

    logic [NQ-1:0]       irq_en, ovf, udf, thr_hit, flush, ovf_set, udf_set, wr_q;
    logic [QBASE_WD-1:0] qbase [NQ];
    logic [QCNT_WD-1:0]  cnt [NQ];
    logic [QCNT_WD-1:0]  cnt_nx [NQ];
    logic [7:0]          thr_rd [NQ];
    logic [31:0]         byte_m, rd_word, wr_word, clr_w;
    logic                req, wr, wr_ctrl, wr_stat, unused_ok;
    logic [2:0]          qa;

    assign req     = wb.wbs_cyc_i & wb.wbs_stb_i;
    assign wr      = req & wb.wbs_we_i & wb.wbs_ack_o;
    assign qa      = wb.wbs_adr_i[4:2];
    assign byte_m  = {{8{wb.wbs_sel_i[3]}}, {8{wb.wbs_sel_i[2]}}, {8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}};
    assign wr_word = (rd_word & ~byte_m) | (wb.wbs_dat_i & byte_m);
    assign wr_ctrl = wr && wb.wbs_adr_i[5:2] == 4'h0;
    assign wr_stat = wr && wb.wbs_adr_i[5:2] == 4'h1;
    assign clr_w   = wr_stat ? (wb.wbs_dat_i & byte_m) : '0;
    assign flush   = wr_ctrl ? wr_word[8 +: NQ] : '0;
    assign unused_ok = ^{wb.wbs_adr_i[1:0], wr_word, clr_w};

    // register read mux; also selects which QCFG slot a write lands in
    always_comb begin
        rd_word = '0;
        wr_q    = '0;
        if (wb.wbs_adr_i[5:2] == 4'h0)
            rd_word = {16'h0, 8'h0, 8'(irq_en)};
        else if (wb.wbs_adr_i[5:2] == 4'h1)
            rd_word = {8'h0, 8'(udf), 8'(ovf), 8'(thr_hit)};
        else if (wb.wbs_adr_i[5])
            for (int q = 0; q < NQ; q++)
                if (qa == 3'(q)) begin
                    rd_word = {8'(cnt[q]), thr_rd[q], 16'(qbase[q])};
                    wr_q[q] = wr;
                end
    end

    // per-queue next count and error events: flush beats inc/dec, inc+dec cancel, ends saturate
    always_comb begin
        for (int q = 0; q < NQ; q++) begin
            ovf_set[q] = !flush[q] && qcnt_inc[q] && !qcnt_dec[q] && cnt[q] == CMAX;
            udf_set[q] = !flush[q] && qcnt_dec[q] && !qcnt_inc[q] && cnt[q] == '0;
            cnt_nx[q]  = flush[q] ? '0 :
                         (qcnt_inc[q] && !qcnt_dec[q] && cnt[q] != CMAX) ? cnt[q] + QCNT_WD'(1) :
                         (qcnt_dec[q] && !qcnt_inc[q] && cnt[q] != '0) ? cnt[q] - QCNT_WD'(1) : cnt[q];
        end
    end

    // bus handshake, control/status registers, counters and irq
    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_dat_o <= '0;
            irq_en       <= '0;
            ovf          <= '0;
            udf          <= '0;
            irq          <= 1'b0;
            for (int q = 0; q < NQ; q++) begin
                qbase[q] <= '0;
                cnt[q]   <= '0;
            end
        end else begin
            wb.wbs_ack_o <= req && !wb.wbs_ack_o;
            wb.wbs_dat_o <= (req && !wb.wbs_ack_o) ? rd_word : '0;
            irq_en       <= wr_ctrl ? wr_word[NQ-1:0] : irq_en;
            ovf          <= (ovf & ~clr_w[8 +: NQ]) | ovf_set;
            udf          <= (udf & ~clr_w[16 +: NQ]) | udf_set;
            irq          <= |((thr_hit | ovf | udf) & irq_en);
            for (int q = 0; q < NQ; q++) begin
                if (wr_q[q])
                    qbase[q] <= wr_word[QBASE_WD-1:0];
                cnt[q] <= cnt_nx[q];
            end
        end
    end

`ifdef QMGR_THRESH_EN
    logic [QCNT_WD-1:0] thresh [NQ];
    logic [NQ-1:0]      thr_set;

    // upward threshold crossings only; a zero threshold is disabled
    always_comb begin
        for (int q = 0; q < NQ; q++) begin
            thr_set[q] = thresh[q] != '0 && cnt[q] < thresh[q] && cnt_nx[q] >= thresh[q];
            thr_rd[q]  = 8'(thresh[q]);
        end
    end

    // threshold registers and sticky hit flags (hardware set beats W1C)
    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            thr_hit <= '0;
            for (int q = 0; q < NQ; q++)
                thresh[q] <= '0;
        end else begin
            thr_hit <= (thr_hit & ~clr_w[0 +: NQ]) | thr_set;
            for (int q = 0; q < NQ; q++)
                if (wr_q[q])
                    thresh[q] <= wr_word[16 +: QCNT_WD];
        end
    end
`else
    assign thr_hit = '0;

    // thresholds absent: fields read as zero
    always_comb begin
        for (int q = 0; q < NQ; q++)
            thr_rd[q] = '0;
    end
`endif

    for (genvar g = 0; g < NQ; g++) begin : g_out
        assign cfg_qbase_addr[g*QBASE_WD +: QBASE_WD] = qbase[g];
        assign qcnt[g*QCNT_WD +: QCNT_WD]             = cnt[g];
        assign q_empty[g]                             = cnt[g] == '0;
        assign q_full[g]                              = cnt[g] == CMAX;
    end
endmodule

// File: tb/tb_mac_qmgr.sv
// tb_mac_qmgr: directed checks of mac_qmgr registers, counters, status and irq (NQ=2, QCNT_WD=4, QBASE_WD=10)
module tb_mac_qmgr;
    localparam int NQ = 2;
`ifdef QMGR_THRESH_EN
    localparam bit THR = 1'b1;
`else
    localparam bit THR = 1'b0;
`endif

    logic          app_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NQ-1:0] qcnt_inc = '0;
    logic [NQ-1:0] qcnt_dec = '0;
    logic [19:0]   cfg_qbase_addr;
    logic [7:0]    qcnt;
    logic [NQ-1:0] q_empty, q_full;
    logic          irq;
    int            vectors = 0;
    int            errs = 0;
    logic [31:0]   rd;

    mac_qmgr_if wbif ();

    mac_qmgr #(.NQ(NQ), .QCNT_WD(4), .QBASE_WD(10)) dut (
        .app_clk(app_clk), .reset_n(reset_n), .wb(wbif),
        .qcnt_inc(qcnt_inc), .qcnt_dec(qcnt_dec),
        .cfg_qbase_addr(cfg_qbase_addr), .qcnt(qcnt),
        .q_empty(q_empty), .q_full(q_full), .irq(irq)
    );

    always #5 app_clk = ~app_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [5:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input logic [NQ-1:0] inc, input logic [NQ-1:0] dec, output logic [31:0] data);
        int n = 0;
        wbif.wbs_cyc_i = 1'b1;
        wbif.wbs_stb_i = 1'b1;
        wbif.wbs_we_i  = we;
        wbif.wbs_adr_i = adr;
        wbif.wbs_dat_i = dat;
        wbif.wbs_sel_i = sel;
        @(negedge app_clk);
        while (!wbif.wbs_ack_o && n < 8) begin
            @(negedge app_clk);
            n++;
        end
        chk("ack", 32'(wbif.wbs_ack_o), 32'h1);
        data     = wbif.wbs_dat_o;
        qcnt_inc = inc;
        qcnt_dec = dec;
        @(negedge app_clk);
        wbif.wbs_cyc_i = 1'b0;
        wbif.wbs_stb_i = 1'b0;
        wbif.wbs_we_i  = 1'b0;
        qcnt_inc = '0;
        qcnt_dec = '0;
    endtask

    task automatic wr(input logic [5:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
        logic [31:0] d;
        xfer(1'b1, adr, dat, sel, '0, '0, d);
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        xfer(1'b0, adr, 32'h0, 4'hF, '0, '0, d);
        chk(tag, d, exp);
    endtask

    task automatic pulse(input logic [NQ-1:0] inc, input logic [NQ-1:0] dec, input int n);
        qcnt_inc = inc;
        qcnt_dec = dec;
        repeat (n) @(negedge app_clk);
        qcnt_inc = '0;
        qcnt_dec = '0;
    endtask

    initial begin
        wbif.wbs_cyc_i = 1'b0;
        wbif.wbs_stb_i = 1'b0;
        wbif.wbs_we_i  = 1'b0;
        wbif.wbs_adr_i = '0;
        wbif.wbs_sel_i = '0;
        wbif.wbs_dat_i = '0;
        repeat (2) @(negedge app_clk);
        reset_n = 1'b1;
        @(negedge app_clk);
        chk("rst_empty", 32'(q_empty), 32'h3);
        chk("rst_full", 32'(q_full), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_qbase", 32'(cfg_qbase_addr), 32'h0);
        chk("rst_qcnt", 32'(qcnt), 32'h0);
        rd_chk("rst_ctrl", 6'h00, 32'h0);
        rd_chk("rst_stat", 6'h04, 32'h0);
        rd_chk("rst_qcfg0", 6'h20, 32'h0);
        rd_chk("rst_qcfg1", 6'h24, 32'h0);

        wr(6'h24, 32'h0000_0155);
        chk("qbase1_out", 32'(cfg_qbase_addr[19:10]), 32'h155);
        chk("qbase0_out", 32'(cfg_qbase_addr[9:0]), 32'h0);
        rd_chk("qcfg1_rd", 6'h24, 32'h0000_0155);
        wr(6'h20, 32'hFFFF_FFFF, 4'b0001);
        rd_chk("sel_lo", 6'h20, 32'h0000_00FF);
        wr(6'h20, 32'h0000_0300, 4'b0010);
        rd_chk("sel_hi", 6'h20, 32'h0000_03FF);
        wr(6'h2C, 32'hFFFF_FFFF);
        wr(6'h08, 32'hFFFF_FFFF);
        rd_chk("unmapped_q3", 6'h2C, 32'h0);
        rd_chk("unmapped_08", 6'h08, 32'h0);
        chk("qbase_after_unmapped", 32'(cfg_qbase_addr), {12'h0, 10'h155, 10'h3FF});

        wr(6'h00, 32'h0000_0001);
        pulse(2'b01, 2'b00, 15);
        chk("cnt15", 32'(qcnt), 32'h0F);
        chk("full15", 32'(q_full), 32'h1);
        chk("empty15", 32'(q_empty), 32'h2);
        pulse(2'b01, 2'b00, 1);
        chk("ovf_hold", 32'(qcnt), 32'h0F);
        chk("irq_t1", 32'(irq), 32'h0);
        @(negedge app_clk);
        chk("irq_t2", 32'(irq), 32'h1);
        rd_chk("ovf_stat", 6'h04, 32'h0000_0100);
        wr(6'h04, 32'h0000_0100);
        rd_chk("ovf_clr", 6'h04, 32'h0);
        chk("irq_clr", 32'(irq), 32'h0);

        pulse(2'b10, 2'b10, 1);
        pulse(2'b00, 2'b10, 1);
        chk("udf_hold", 32'(qcnt[7:4]), 32'h0);
        rd_chk("udf_stat", 6'h04, 32'h0002_0000);
        chk("irq_masked", 32'(irq), 32'h0);
        wr(6'h04, 32'h0002_0000);
        rd_chk("udf_clr", 6'h04, 32'h0);
        xfer(1'b1, 6'h04, 32'h0002_0000, 4'hF, 2'b00, 2'b10, rd);
        rd_chk("set_beats_clr", 6'h04, 32'h0002_0000);
        wr(6'h04, 32'h00FF_FFFF);
        rd_chk("stat_clr_all", 6'h04, 32'h0);

        pulse(2'b00, 2'b01, 8);
        chk("cnt7", 32'(qcnt[3:0]), 32'h7);
        rd_chk("qcfg0_cnt7", 6'h20, 32'h0700_03FF);
        xfer(1'b1, 6'h00, 32'h0000_0101, 4'hF, 2'b01, 2'b00, rd);
        chk("flush_cnt", 32'(qcnt[3:0]), 32'h0);
        chk("flush_empty", 32'(q_empty), 32'h3);
        rd_chk("ctrl_flush_rd0", 6'h00, 32'h0000_0001);
        rd_chk("flush_no_stat", 6'h04, 32'h0);

        wr(6'h20, 32'h0004_03FF);
        rd_chk("thresh_rd", 6'h20, THR ? 32'h0004_03FF : 32'h0000_03FF);
        rd_chk("thresh_wr_no_hit", 6'h04, 32'h0);
        pulse(2'b01, 2'b00, 3);
        pulse(2'b01, 2'b01, 1);
        chk("incdec_cnt", 32'(qcnt[3:0]), 32'h3);
        rd_chk("incdec_no_hit", 6'h04, 32'h0);
        pulse(2'b01, 2'b00, 1);
        chk("cnt4", 32'(qcnt[3:0]), 32'h4);
        rd_chk("thr_hit", 6'h04, THR ? 32'h0000_0001 : 32'h0);
        chk("thr_irq", 32'(irq), THR ? 32'h1 : 32'h0);

        wbif.wbs_cyc_i = 1'b1;
        wbif.wbs_stb_i = 1'b1;
        wbif.wbs_we_i  = 1'b1;
        wbif.wbs_adr_i = 6'h24;
        wbif.wbs_dat_i = 32'h0000_00AA;
        wbif.wbs_sel_i = 4'hF;
        @(negedge app_clk);
        chk("mid_ack_up", 32'(wbif.wbs_ack_o), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_ack_drop", 32'(wbif.wbs_ack_o), 32'h0);
        chk("mid_qbase", 32'(cfg_qbase_addr), 32'h0);
        wbif.wbs_cyc_i = 1'b0;
        wbif.wbs_stb_i = 1'b0;
        wbif.wbs_we_i  = 1'b0;
        @(negedge app_clk);
        reset_n = 1'b1;
        @(negedge app_clk);
        chk("post_qcnt", 32'(qcnt), 32'h0);
        chk("post_irq", 32'(irq), 32'h0);
        rd_chk("post_qcfg1", 6'h24, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mac_qmgr.md
# mac_qmgr

Parametrised descriptor-queue occupancy manager for the GMAC subsystem. It generalises the fixed pair of 4-bit TX/RX queue counters to NQ queues of configurable depth. It adds per-queue base-address and threshold registers, saturating counters, overflow/underflow error capture and a maskable interrupt, all behind a Wishbone register slave. It sits beside the MAC core in the mac wrapper on app_clk and feeds queue base addresses and occupancy to the mem2mem DMA engines.

## Interface
Parameters:
- NQ, 2, number of queues (1..8)
- QCNT_WD, 4, counter width in bits (2..8); the maximum count is 2^QCNT_WD-1
- QBASE_WD, 10, queue base-address width in bits (1..16)

Ports:
- app_clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_adr_i  in  6  byte address; [1:0] ignored
- wbs_sel_i  in  4  byte enables
- wbs_dat_i  in  32  write data
- wbs_dat_o  out  32  read data
- wbs_ack_o  out  1  acknowledge
- qcnt_inc  in  NQ  per-queue increment pulse
- qcnt_dec  in  NQ  per-queue decrement pulse
- cfg_qbase_addr  out  NQ*QBASE_WD  queue base addresses; queue q occupies slice [q*QBASE_WD +: QBASE_WD]
- qcnt  out  NQ*QCNT_WD  per-queue counts
- q_empty  out  NQ  count==0
- q_full  out  NQ  count==max
- irq  out  1  registered interrupt

## Operation
Register map:
- 0x00 CTRL
  - [7:0] irq_en, RW
  - [15:8] flush, write-1, self-clearing, reads 0
- 0x04 INT_STATUS, W1C
  - [7:0] thr_hit
  - [15:8] ovf
  - [23:16] udf
- 0x20+4q QCFG(q), for q<NQ
  - [15:0] qbase, RW; only the low QBASE_WD bits are stored
  - [23:16] thresh, RW; only the low QCNT_WD bits are stored
  - [31:24] count, RO, zero-extended
- Bits and queues at or above NQ, and unmapped addresses, read 0. Writes to them are ignored.
- RW fields honour wbs_sel_i per byte.

Counter update per queue, applied each cycle in this priority:
1. flush[q] written this cycle: count becomes 0. Inc and dec in the same cycle are dropped.
2. inc and dec together: count unchanged.
3. inc only:
   - below max: count+1.
   - at max: count held, ovf[q] set.
4. dec only:
   - above 0: count-1.
   - at 0: count held at 0, udf[q] set.

Threshold (QMGR_THRESH_EN):
- thr_hit[q] is set when thresh!=0, count<thresh and count_next>=thresh. Only upward crossings count.
- Writing a new thresh value never sets thr_hit.

INT_STATUS:
- A hardware set and a software W1C of the same bit in the same cycle: the set wins.

irq:
- irq <= |(INT_STATUS[7:0] & irq_en) | |(INT_STATUS[15:8] & irq_en) | |(INT_STATUS[23:16] & irq_en).
- irq_en[q] gates all three status bits of queue q.

## Timing
- Reset: all registers, counters, wbs_dat_o and wbs_ack_o go to 0. The outputs then read q_empty=all 1, q_full=0, irq=0, cfg_qbase_addr=0.
- Wishbone:
  - wbs_ack_o asserts one cycle after wbs_cyc_i & wbs_stb_i & !wbs_ack_o. It is a single-cycle pulse, so the minimum access is 2 cycles.
  - Read data is registered and valid with ack.
  - The write takes effect on the ack cycle; its effect is visible in the following cycle.
- Counter latency: qcnt, q_empty and q_full update 1 cycle after an inc/dec pulse. An inc/dec asserted for N cycles counts N times.
- Status latency: a status bit sets 1 cycle after the triggering event; irq follows 1 cycle later.
- A QCFG read returns the count as of the ack edge.
- Asynchronous reset mid-transfer drops ack immediately. No partial write is retained.

## Configuration
- QMGR_THRESH_EN defined:
  - thresh registers exist.
  - thr_hit logic is active.
- QMGR_THRESH_EN undefined:
  - thresh fields read 0 and writes to them are ignored.
  - thr_hit bits are tied to 0.
  - irq is driven only by ovf and udf.
  - No threshold comparators are synthesised.

## Test plan
- Reset with NQ=2, QCNT_WD=4: all registers read 0, q_empty=2'b11, irq=0. Write QCFG(1)=0x0000_0155, then cfg_qbase_addr[19:10]=10'h155.
- 15 inc pulses on queue 0: count=15 and q_full[0]=1. A 16th inc keeps the count at 15 and sets INT_STATUS[8]. With irq_en[0]=1, irq rises 2 cycles after the 16th inc.
- Queue 1 at 0, then dec: count stays 0 and INT_STATUS[17] is set. Write 0x0002_0000 to INT_STATUS: the bit clears. Repeat the clear in the same cycle as a new underflow: the bit stays 1.
- thresh(0)=4, count=3, then inc: thr_hit[0] set. Simultaneous inc and dec at count 3: count unchanged, no thr_hit. With QMGR_THRESH_EN undefined, the thresh field reads 0 and there is no hit.
- Count=7 on queue 0, write CTRL flush=0x01 in the same cycle as an inc pulse: count=0 the next cycle, CTRL[15:8] reads 0.
